fir_mac_filter: RTL

FIR_MAC_FILTER -- requirements
Module: fir_mac_filter

---
 rtl/fir_mac_pkg.sv | 21 ++
 rtl/fir_mac_sat.sv | 42 ++++
 rtl/fir_mac_filter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/fir_mac_pkg.sv
// fir_mac_pkg: shared FSM state type and width helpers for the
// sequential-MAC FIR filter (fir_mac_filter and fir_mac_sat).
package fir_mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Accumulator width: full product plus enough guard bits for NTAPS sums.
   function automatic int calc_acc_w(input int data_w, input int coef_w, input int ntaps);
      return data_w + coef_w + $clog2(ntaps);
   endfunction

   // Width of the shift control able to address every accumulator bit.
   function automatic int calc_sw(input int acc_w);
      return $clog2(acc_w);
   endfunction

endpackage

// File: rtl/fir_mac_sat.sv
// fir_mac_sat: combinational arithmetic right shift and saturation of the
// accumulator down to the output sample width.
//   acc_i   : signed accumulator value
//   shift_i : requested right-shift amount (clamped to ACC_W-1)
//   data_o  : shifted, clamped signed sample
//   sat_o   : high when clamping changed the value
module fir_mac_sat
   import fir_mac_pkg::*;
#(
   parameter  int ACC_W  = 18,
   parameter  int DATA_W = 8,
   localparam int SW     = calc_sw(ACC_W)
) (
   input  logic signed [ACC_W-1:0]  acc_i,
   input  logic        [SW-1:0]     shift_i,
   output logic signed [DATA_W-1:0] data_o,
   output logic                     sat_o
);

   localparam logic        [SW-1:0]    SHIFT_MAX = SW'(ACC_W - 1);
   localparam logic signed [ACC_W-1:0] MAX_V     = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] MIN_V     = ~MAX_V;

   logic        [SW-1:0]    shift_amt;
   logic signed [ACC_W-1:0] shifted;

   always_comb begin
      shift_amt = (shift_i > SHIFT_MAX) ? SHIFT_MAX : shift_i;
      // >>> on a signed operand floors toward minus infinity; no rounding.
      shifted   = acc_i >>> shift_amt;
      sat_o     = 1'b0;
      data_o    = shifted[DATA_W-1:0];
      if (shifted > MAX_V) begin
         data_o = MAX_V[DATA_W-1:0];
         sat_o  = 1'b1;
      end else if (shifted < MIN_V) begin
         data_o = MIN_V[DATA_W-1:0];
         sat_o  = 1'b1;
      end
   end

endmodule

// File: rtl/fir_mac_filter.sv
// fir_mac_filter: NTAPS-tap FIR filter using one shared multiplier that
// walks the taps one per cycle (IDLE -> MAC x NTAPS -> DONE).
//   clk, reset              : single clock, synchronous active-high reset
//   enable, clear           : run/freeze control and synchronous flush
//   in_valid/in_ready/data_in : sample input handshake
//   coef_we/coef_addr/coef_wdata : coefficient write port (IDLE only)
//   shift                   : output arithmetic right-shift amount
//   data_out/out_valid/sat_flag : result, one-cycle strobe, saturation flag
//   busy, coef_wr_err       : computation in progress, rejected write pulse
module fir_mac_filter
   import fir_mac_pkg::*;
#(
   parameter  int DATA_W = 8,
   parameter  int COEF_W = 8,
   parameter  int NTAPS  = 3,
   localparam int ACC_W  = calc_acc_w(DATA_W, COEF_W, NTAPS),
   localparam int AW     = $clog2(NTAPS),
   localparam int SW     = calc_sw(ACC_W)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     clear,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] data_in,
   input  logic                     coef_we,
   input  logic        [AW-1:0]     coef_addr,
   input  logic signed [COEF_W-1:0] coef_wdata,
   input  logic        [SW-1:0]     shift,
   output logic signed [DATA_W-1:0] data_out,
   output logic                     out_valid,
   output logic                     sat_flag,
   output logic                     busy,
   output logic                     coef_wr_err
);

   localparam int            PROD_W   = DATA_W + COEF_W;
   localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

   state_e                   state_q, state_d;
   logic        [AW-1:0]     tap_q, tap_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [DATA_W-1:0] x_q [NTAPS];
   logic signed [DATA_W-1:0] x_d [NTAPS];
   logic signed [COEF_W-1:0] c_q [NTAPS];
   logic signed [DATA_W-1:0] data_out_q;
   logic                     coef_wr_err_q;

   logic signed [PROD_W-1:0] prod;
   logic signed [DATA_W-1:0] sat_data;
   logic                     sat_hit;
   logic                     addr_ok;
   logic                     coef_ok;
   logic                     coef_bad;

   // The one shared multiplier; the tap counter selects sample and coefficient.
   assign prod = PROD_W'(x_q[tap_q]) * PROD_W'(c_q[tap_q]);

   // Writes land only between computations so a running sum never sees a
   // coefficient change halfway through; clear drops the write silently.
   assign addr_ok  = int'(coef_addr) < NTAPS;
   assign coef_ok  = coef_we & ~clear & (state_q == IDLE) & addr_ok;
   assign coef_bad = coef_we & ~clear & ~((state_q == IDLE) & addr_ok);

   assign in_ready    = (state_q == IDLE) & enable & ~clear & ~reset;
   assign out_valid   = (state_q == DONE) & enable & ~clear & ~reset;
   assign sat_flag    = out_valid & sat_hit;
   assign busy        = (state_q != IDLE);
   assign coef_wr_err = coef_wr_err_q;
   // The new result is visible during DONE itself and held afterwards.
   assign data_out    = out_valid ? sat_data : data_out_q;

   fir_mac_sat #(
      .ACC_W (ACC_W),
      .DATA_W(DATA_W)
   ) u_sat (
      .acc_i  (acc_q),
      .shift_i(shift),
      .data_o (sat_data),
      .sat_o  (sat_hit)
   );

   // NOTE: every next-state signal gets its hold value first, so no path
   // through this block leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      tap_d   = tap_q;
      acc_d   = acc_q;
      x_d     = x_q;
      if (clear) begin
         state_d = IDLE;
         tap_d   = '0;
         acc_d   = '0;
         for (int i = 0; i < NTAPS; i++) x_d[i] = '0;
      end else if (enable) begin
         unique case (state_q)
            IDLE: begin
               if (in_valid) begin
                  x_d[0] = data_in;
                  for (int i = 1; i < NTAPS; i++) x_d[i] = x_q[i-1];
                  acc_d   = '0;
                  tap_d   = '0;
                  state_d = MAC;
               end
            end
            MAC: begin
               acc_d = acc_q + ACC_W'(prod);
               // Stop at the last tap instead of wrapping into a second pass.
               if (tap_q == LAST_TAP) state_d = DONE;
               else                   tap_d   = tap_q + AW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         tap_q         <= '0;
         acc_q         <= '0;
         data_out_q    <= '0;
         coef_wr_err_q <= 1'b0;
         // NOTE: the delay line and coefficient array are flops rather than
         // RAM, so they can and must be cleared here for a known start.
         for (int i = 0; i < NTAPS; i++) begin
            x_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         tap_q         <= tap_d;
         acc_q         <= acc_d;
         x_q           <= x_d;
         coef_wr_err_q <= coef_bad;
         if (coef_ok)   c_q[coef_addr] <= coef_wdata;
         if (out_valid) data_out_q     <= sat_data;
      end
   end

endmodule
